// File: rtl/mac_arb_pkg.sv
// Shared constants, state encodings and result-tag layout for the
// two-requester multiply-add arbiter.
package mac_arb_pkg;
  localparam int W   = 32;
  localparam int LAT = 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BURST0 = 2'd1;
  localparam logic [1:0] BURST1 = 2'd2;

  localparam int TAG_W    = 3;
  localparam int TAG_V    = 2;
  localparam int TAG_ID   = 1;
  localparam int TAG_LAST = 0;

  typedef struct packed {
    logic v;
    logic id;
    logic last;
  } tag_t;
endpackage

// File: rtl/mac2_pipe.sv
// Two-stage dual multiply-add: c = a1*b1 + a2*b2 (mod 2^DW).
// Free-running with no reset; idle cycles simply carry zero operands.
module mac2_pipe
  import mac_arb_pkg::*;
#(
  parameter int DW = W
) (
  input  logic          clk,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] a2,
  input  logic [DW-1:0] b1,
  input  logic [DW-1:0] b2,
  output logic [DW-1:0] c
);
  logic [DW-1:0] p1, p2;

  always_ff @(posedge clk) begin
    p1 <= a1 * b1;
    p2 <= a2 * b2;
    c  <= p1 + p2;
  end
endmodule

// File: rtl/mac_arbiter.sv
// Burst-granting round-robin arbiter in front of a shared mac2_pipe; a tag
// shift register tracks issued beats so results come back labelled.
module mac_arbiter
  import mac_arb_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic         req0_last,
  input  logic [W-1:0] req0_a1,
  input  logic [W-1:0] req0_a2,
  input  logic [W-1:0] req0_b1,
  input  logic [W-1:0] req0_b2,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic         req1_last,
  input  logic [W-1:0] req1_a1,
  input  logic [W-1:0] req1_a2,
  input  logic [W-1:0] req1_b1,
  input  logic [W-1:0] req1_b2,
  output logic         req1_ready,
  output logic         res_valid,
  output logic         res_id,
  output logic         res_last,
  output logic [W-1:0] res_data,
  output logic         busy
);
  logic [1:0]     state, state_nxt;
  logic           rr_last;
  logic           gnt0, gnt1, xfer, xid, xlast;
  logic [W-1:0]   a1, a2, b1, b2;
  tag_t           issue_tag;
  tag_t [LAT:1]   tag_pipe;

  // Owner of a burst keeps the grant even while its valid is low.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      BURST0:  gnt0 = 1'b1;
      BURST1:  gnt1 = 1'b1;
      default: begin
        if (req0_valid && req1_valid) begin
          gnt0 = rr_last;
          gnt1 = !rr_last;
        end else begin
          gnt0 = req0_valid;
          gnt1 = req1_valid;
        end
      end
    endcase
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign xfer  = (req0_valid && gnt0) || (req1_valid && gnt1);
  assign xid   = req1_valid && gnt1;
  assign xlast = xid ? req1_last : req0_last;

  always_comb begin
    a1 = '0;
    a2 = '0;
    b1 = '0;
    b2 = '0;
    if (xfer) begin
      a1 = xid ? req1_a1 : req0_a1;
      a2 = xid ? req1_a2 : req0_a2;
      b1 = xid ? req1_b1 : req0_b1;
      b2 = xid ? req1_b2 : req0_b2;
    end
  end

  always_comb begin
    state_nxt = state;
    if (xfer) begin
      case (state)
        IDLE:    if (!xlast) state_nxt = xid ? BURST1 : BURST0;
        default: if (xlast) state_nxt = IDLE;
      endcase
    end
  end

  assign issue_tag = '{v: xfer, id: xid, last: xlast};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_last  <= 1'b1;
      tag_pipe <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) rr_last <= xid;
      tag_pipe[1] <= issue_tag;
      for (int i = 2; i <= LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  mac2_pipe #(.DW(W)) u_mac (
    .clk (clk),
    .a1  (a1),
    .a2  (a2),
    .b1  (b1),
    .b2  (b2),
    .c   (res_data)
  );

  assign res_valid = tag_pipe[LAT].v;
  assign res_id    = tag_pipe[LAT].id;
  assign res_last  = tag_pipe[LAT].last;

  always_comb begin
    busy = (state != IDLE);
    for (int i = 1; i <= LAT; i++) busy = busy | tag_pipe[i].v;
  end
endmodule

// File: tb/tb_mac_arbiter.sv
// Directed bench for mac_arbiter: hand-computed results, grant order,
// burst locking, wrap-around and reset abandonment.
module tb_mac_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_last, req0_ready;
  logic [31:0] req0_a1, req0_a2, req0_b1, req0_b2;
  logic        req1_valid, req1_last, req1_ready;
  logic [31:0] req1_a1, req1_a2, req1_b1, req1_b2;
  logic        res_valid, res_id, res_last, busy;
  logic [31:0] res_data;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mac_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_last(req0_last),
    .req0_a1(req0_a1), .req0_a2(req0_a2), .req0_b1(req0_b1), .req0_b2(req0_b2),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_last(req1_last),
    .req1_a1(req1_a1), .req1_a2(req1_a2), .req1_b1(req1_b1), .req1_b2(req1_b2),
    .req1_ready(req1_ready),
    .res_valid(res_valid), .res_id(res_id), .res_last(res_last),
    .res_data(res_data), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat0(input logic v, input logic l, input logic [31:0] a1, a2, b1, b2);
    req0_valid = v; req0_last = l;
    req0_a1 = a1; req0_a2 = a2; req0_b1 = b1; req0_b2 = b2;
  endtask

  task automatic beat1(input logic v, input logic l, input logic [31:0] a1, a2, b1, b2);
    req1_valid = v; req1_last = l;
    req1_a1 = a1; req1_a2 = a2; req1_b1 = b1; req1_b2 = b2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic id, input logic l, input logic [31:0] d);
    chk({tag, "_v"}, res_valid, 1);
    chk({tag, "_id"}, res_id, id);
    chk({tag, "_last"}, res_last, l);
    chk({tag, "_data"}, res_data, d);
  endtask

  initial begin
    beat0(0, 0, 0, 0, 0, 0);
    beat1(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_res_last", res_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    reset = 1'b0;

    // single beat: 3*5 + 4*6 = 39
    beat0(1, 1, 3, 4, 5, 6);
    #1;
    chk("single_rdy0", req0_ready, 1);
    chk("single_rdy1", req1_ready, 0);
    tick();
    beat0(0, 0, 0, 0, 0, 0);
    chk("single_lat1_v", res_valid, 0);
    chk("single_lat1_busy", busy, 1);
    tick();
    chk_res("single", 0, 1, 39);
    chk("single_busy", busy, 1);
    tick();
    chk("single_after_v", res_valid, 0);
    chk("single_after_busy", busy, 0);

    // alternating grants; req0 yields 1, req1 yields 2
    do_reset();
    beat0(1, 1, 1, 0, 1, 0);
    beat1(1, 1, 2, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_rdy0", req0_ready, (i % 2 == 0));
      chk("alt_rdy1", req1_ready, (i % 2 == 1));
      if (i >= 2) chk_res("alt", (i % 2), 1, ((i % 2) == 0) ? 1 : 2);
      tick();
    end
    beat0(0, 0, 0, 0, 0, 0);
    beat1(0, 0, 0, 0, 0, 0);
    chk_res("alt_b2", 0, 1, 1);
    tick();
    chk_res("alt_b3", 1, 1, 2);
    tick();
    chk("alt_drain_v", res_valid, 0);

    // req0 3-beat burst holds off req1: results 6, 12, 15 then req1's 7
    do_reset();
    beat1(1, 1, 7, 0, 1, 0);
    beat0(1, 0, 2, 0, 3, 0);
    #1;
    chk("bst_b0_rdy0", req0_ready, 1);
    chk("bst_b0_rdy1", req1_ready, 0);
    tick();
    beat0(1, 0, 4, 0, 3, 0);
    #1;
    chk("bst_b1_rdy1", req1_ready, 0);
    tick();
    beat0(1, 1, 5, 0, 3, 0);
    #1;
    chk("bst_b2_rdy1", req1_ready, 0);
    chk_res("bst_r0", 0, 0, 6);
    tick();
    beat0(0, 0, 0, 0, 0, 0);
    #1;
    chk("bst_post_rdy1", req1_ready, 1);
    chk("bst_post_rdy0", req0_ready, 0);
    chk_res("bst_r1", 0, 0, 12);
    tick();
    beat1(0, 0, 0, 0, 0, 0);
    chk_res("bst_r2", 0, 1, 15);
    tick();
    chk_res("bst_r3", 1, 1, 7);
    tick();
    chk("bst_drain_v", res_valid, 0);

    // wrap-around: (2^32-1)^2 + 4 = 5 mod 2^32
    beat0(1, 1, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 2);
    tick();
    beat0(0, 0, 0, 0, 0, 0);
    tick();
    chk_res("ovf", 0, 1, 32'h0000_0005);
    tick();

    // reset one cycle after a transfer abandons the beat and the burst
    beat0(1, 0, 9, 9, 9, 9);
    tick();
    beat0(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_v", res_valid, 0);
    chk("mid_rst_busy", busy, 0);
    beat1(1, 1, 0, 0, 0, 0);
    #1;
    chk("mid_rst_idle_rdy1", req1_ready, 1);
    beat1(0, 0, 0, 0, 0, 0);
    #1;
    tick();
    chk("mid_rst_v2", res_valid, 0);
    chk("mid_rst_busy2", busy, 0);

    // BURST1 with a 4-cycle valid gap: req0 starves, results 10, 20, 30
    do_reset();
    beat1(1, 0, 1, 0, 10, 0);
    tick();
    beat1(1, 0, 2, 0, 10, 0);
    tick();
    beat1(0, 0, 0, 0, 0, 0);
    beat0(1, 1, 1, 1, 1, 1);
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("gap_rdy0", req0_ready, 0);
      chk("gap_rdy1", req1_ready, 1);
      chk("gap_busy", busy, 1);
      if (j == 0) chk_res("gap_r0", 1, 0, 10);
      else if (j == 1) chk_res("gap_r1", 1, 0, 20);
      else chk("gap_idle_v", res_valid, 0);
      tick();
    end
    beat0(0, 0, 0, 0, 0, 0);
    beat1(1, 1, 3, 0, 10, 0);
    #1;
    chk("gap_resume_rdy1", req1_ready, 1);
    tick();
    beat1(0, 0, 0, 0, 0, 0);
    chk("gap_resume_lat1", res_valid, 0);
    tick();
    chk_res("gap_r2", 1, 1, 30);
    tick();
    chk("gap_drain_v", res_valid, 0);
    chk("gap_drain_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
